nn_frame_sequencer: RTL and testbench

Parametrised frame-capture and inference sequencer between the UART byte receiver and the neural network core. It buffers one full image of pixel bytes and debounces the start request. It launches the core with a one-cycle start pulse, captures the argmax result on done, and tracks frames and errors for LED and HEX status. It generalises the current fixed top-level flow to any image size and class width, and adds overrun detection, an explicit frame-complete state and a result history.

---
 rtl/nn_frame_sequencer_if.sv | 25 ++
 rtl/nn_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_nn_frame_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_frame_sequencer_if.sv
// Byte stream, pixel-buffer read port and NN core handshake shared by the frame sequencer
// (master modport) and the UART receiver / NN core side (slave modport).
interface nn_frame_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int PIX_W   = 8,
  parameter int CLASS_W = 4
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic [ADDR_W-1:0]  pix_rd_addr;
  logic [PIX_W-1:0]   pix_rd_data;
  logic               nn_start;
  logic               nn_done;
  logic [CLASS_W-1:0] nn_argmax;

  modport master (
    input  rx_valid, rx_data, pix_rd_addr, nn_done, nn_argmax,
    output pix_rd_data, nn_start
  );

  modport slave (
    output rx_valid, rx_data, pix_rd_addr, nn_done, nn_argmax,
    input  pix_rd_data, nn_start
  );
endinterface

// File: rtl/nn_frame_sequencer.sv
// Frame-capture and inference sequencer: buffers one image from the UART, launches the NN core
// and tracks results. Define NN_AUTO_START_EN to launch automatically once the last pixel lands.
module nn_frame_sequencer #(
  parameter int NUM_PIXELS      = 784,
  parameter int ADDR_W          = 10,
  parameter int PIX_W           = 8,
  parameter int CLASS_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HIST_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_req,
  nn_frame_sequencer_if.master          bus,
  output logic [CLASS_W-1:0]            result,
  output logic                          result_valid,
  output logic [HIST_DEPTH*CLASS_W-1:0] hist_flat,
  output logic [7:0]                    frame_count,
  output logic                          overrun,
  output logic [3:0]                    state
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_READY = 4'd2,
    ST_RUN   = 4'd3,
    ST_DONE  = 4'd4
  } state_t;

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam int                HIST_W    = HIST_DEPTH * CLASS_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            cur_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [PIX_W-1:0]  pix_mem [DEPTH];
  logic [PIX_W-1:0]  pix_rd_q;
  logic              nn_start_q;
  logic              accepting;
  logic              wr_en;
  logic              wr_last;
  logic [ADDR_W-1:0] wr_addr;

  // A byte arriving in IDLE/DONE always starts a fresh frame at address 0.
  always_comb begin
    accepting = (cur_state == ST_IDLE) || (cur_state == ST_DONE) || (cur_state == ST_LOAD);
    wr_en     = bus.rx_valid && accepting && !reset;
    wr_addr   = (cur_state == ST_LOAD) ? wr_ptr : '0;
    wr_last   = (wr_addr == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pix_mem[wr_addr] <= bus.rx_data[PIX_W-1:0];
    end
  end

  // Registered read; a same-cycle write to the same address is seen one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_rd_q <= '0;
    end else begin
      pix_rd_q <= pix_mem[bus.pix_rd_addr];
    end
  end

`ifdef NN_AUTO_START_EN
  logic unused_start_req;
  assign unused_start_req = start_req;
`else
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] deb_cnt;
  logic             deb_level;
  logic             deb_level_d;
  logic             start_launch;

  // Counter saturates so a held button keeps the debounced level high without re-triggering.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt     <= '0;
      deb_level   <= 1'b0;
      deb_level_d <= 1'b0;
    end else begin
      deb_level_d <= deb_level;
      if (!start_req) begin
        deb_cnt   <= '0;
        deb_level <= 1'b0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt   <= deb_cnt + CNT_W'(1);
        deb_level <= ((deb_cnt + CNT_W'(1)) == DEB_MAX);
      end
    end
  end

  assign start_launch = deb_level & ~deb_level_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= ST_IDLE;
      wr_ptr       <= '0;
      nn_start_q   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      hist_flat    <= '0;
      frame_count  <= '0;
      overrun      <= 1'b0;
    end else begin
      nn_start_q <= 1'b0;
      case (cur_state)
        ST_IDLE, ST_DONE, ST_LOAD: begin
          if (wr_en) begin
            if (wr_last) begin
              wr_ptr <= '0;
`ifdef NN_AUTO_START_EN
              nn_start_q   <= 1'b1;
              result_valid <= 1'b0;
              cur_state    <= ST_RUN;
`else
              cur_state    <= ST_READY;
`endif
            end else begin
              wr_ptr    <= wr_addr + ADDR_W'(1);
              cur_state <= ST_LOAD;
            end
          end
        end
        ST_READY: begin
          if (bus.rx_valid) begin
            overrun <= 1'b1;
          end
`ifndef NN_AUTO_START_EN
          if (start_launch) begin
            nn_start_q   <= 1'b1;
            result_valid <= 1'b0;
            cur_state    <= ST_RUN;
          end
`endif
        end
        ST_RUN: begin
          if (bus.rx_valid) begin
            overrun <= 1'b1;
          end
          // Newest result enters the low slice; the oldest falls off the top.
          if (bus.nn_done) begin
            result       <= bus.nn_argmax;
            result_valid <= 1'b1;
            hist_flat    <= (hist_flat << CLASS_W) | HIST_W'(bus.nn_argmax);
            frame_count  <= frame_count + 8'd1;
            cur_state    <= ST_DONE;
          end
        end
        default: cur_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.nn_start    = nn_start_q;
  assign bus.pix_rd_data = pix_rd_q;
  assign state           = cur_state;

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Scoreboard bench for nn_frame_sequencer: randomized frames checked against a behavioural model
// of the pixel buffer, launch timing and result history.
module tb_nn_frame_sequencer;
  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 10;
  localparam int PIX_W      = 8;
  localparam int CLASS_W    = 4;
  localparam int DEB        = 16;
  localparam int HIST_DEPTH = 4;
  localparam int HIST_W     = HIST_DEPTH * CLASS_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               start_req;
  logic [CLASS_W-1:0] result;
  logic               result_valid;
  logic [HIST_W-1:0]  hist_flat;
  logic [7:0]         frame_count;
  logic               overrun;
  logic [3:0]         state;

  nn_frame_sequencer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .CLASS_W(CLASS_W)) bus ();

  nn_frame_sequencer #(
    .NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CLASS_W(CLASS_W),
    .DEBOUNCE_CYCLES(DEB), .HIST_DEPTH(HIST_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .bus(bus),
    .result(result), .result_valid(result_valid), .hist_flat(hist_flat),
    .frame_count(frame_count), .overrun(overrun), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [7:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [3:0] res; logic [HIST_W-1:0] hist; logic [7:0] fc; logic ovr; } done_exp_t;

  rd_exp_t   rd_q[$];
  int        start_q[$];
  done_exp_t done_q[$];

  // Behavioural model: image contents, byte position within the frame, phase, results.
  logic [7:0] model_mem [NUM_PIXELS];
  bit         model_known [NUM_PIXELS];
  int         model_pos;
  int         model_state;
  int         model_hist[$];
  int         model_fc;
  bit         model_ovr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HIST_W-1:0] hist_pack();
    logic [HIST_W-1:0] h = '0;
    for (int k = 0; k < model_hist.size() && k < HIST_DEPTH; k++)
      h |= HIST_W'(model_hist[k]) << (CLASS_W * k);
    return h;
  endfunction

  // One rx byte; optionally probe the written address in the same cycle.
  task automatic applyStimulus(input logic [7:0] data, input bit probe);
    rd_exp_t re;
    int idx;
    bus.rx_valid = 1'b1;
    bus.rx_data  = data;
    if (model_state == 0 || model_state == 1 || model_state == 4) begin
      idx = (model_state == 1) ? model_pos : 0;
      if (probe && model_known[idx]) begin
        bus.pix_rd_addr = ADDR_W'(idx);
        re.cyc  = cyc + 1;
        re.data = model_mem[idx];
        rd_q.push_back(re);
      end
      model_mem[idx]   = data;
      model_known[idx] = 1'b1;
      if (idx == NUM_PIXELS - 1) begin
        model_pos = 0;
`ifdef NN_AUTO_START_EN
        model_state = 3;
        start_q.push_back(cyc + 1);
`else
        model_state = 2;
`endif
      end else begin
        model_pos   = idx + 1;
        model_state = 1;
      end
    end else begin
      model_ovr = 1'b1;
    end
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic read_pixel(input int addr);
    rd_exp_t re;
    bus.pix_rd_addr = ADDR_W'(addr);
    re.cyc  = cyc + 1;
    re.data = model_mem[addr];
    rd_q.push_back(re);
    step();
  endtask

  task automatic load_frame(input bit ramp, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      applyStimulus(ramp ? 8'(i) : 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // Hold the button 20 cycles; the debounced edge launches 17 cycles after the rise.
  task automatic launch();
    start_req = 1'b1;
`ifndef NN_AUTO_START_EN
    if (model_state == 2) start_q.push_back(cyc + DEB + 1);
`endif
    repeat (20) step();
    start_req = 1'b0;
    step();
    if (model_state == 2) model_state = 3;
  endtask

  task automatic finish_inference(input logic [3:0] argmax, input bit with_rx, input logic [7:0] rx);
    done_exp_t de;
    bus.nn_done   = 1'b1;
    bus.nn_argmax = argmax;
    if (with_rx) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = rx;
    end
    if (model_state == 3) begin
      model_hist.push_front(int'(argmax));
      if (model_hist.size() > HIST_DEPTH) void'(model_hist.pop_back());
      model_fc = (model_fc + 1) % 256;
      if (with_rx) model_ovr = 1'b1;
      de.cyc  = cyc + 1;
      de.res  = argmax;
      de.hist = hist_pack();
      de.fc   = 8'(model_fc);
      de.ovr  = model_ovr;
      done_q.push_back(de);
      model_state = 4;
    end
    step();
    bus.nn_done  = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.nn_done  = 1'b0;
    start_req    = 1'b0;
    step();
    step();
    checkOutput("rst_state", state, 0);
    checkOutput("rst_nn_start", bus.nn_start, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_result_valid", result_valid, 0);
    checkOutput("rst_hist", hist_flat, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_pix_rd_data", bus.pix_rd_data, 0);
    reset       = 1'b0;
    model_state = 0;
    model_pos   = 0;
    model_fc    = 0;
    model_ovr   = 1'b0;
    model_hist.delete();
  endtask

  // Monitor: pops expectations whenever the DUT presents read data, a launch or a new result.
  logic [7:0] prev_fc;
  always @(negedge clk) begin
    rd_exp_t   re;
    done_exp_t de;
    int        se;
    if (reset !== 1'b0) begin
      prev_fc = frame_count;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        re = rd_q.pop_front();
        checkOutput("pix_rd_data", bus.pix_rd_data, re.data);
      end
      if (bus.nn_start === 1'b1) begin
        if (start_q.size() == 0) checkOutput("nn_start_unexpected", bus.nn_start, 0);
        else begin
          se = start_q.pop_front();
          checkOutput("nn_start_cycle", cyc, se);
        end
      end else if (start_q.size() > 0 && start_q[0] < cyc) begin
        void'(start_q.pop_front());
        checkOutput("nn_start_missing", bus.nn_start, 1);
      end
      if (frame_count !== prev_fc) begin
        if (done_q.size() == 0) checkOutput("frame_count_unexpected", frame_count, prev_fc);
        else begin
          de = done_q.pop_front();
          checkOutput("done_cycle", cyc, de.cyc);
          checkOutput("done_result", result, de.res);
          checkOutput("done_result_valid", result_valid, 1);
          checkOutput("done_hist", hist_flat, de.hist);
          checkOutput("done_frame_count", frame_count, de.fc);
          checkOutput("done_overrun", overrun, de.ovr);
          checkOutput("done_state", state, 4);
        end
      end else if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        de = done_q.pop_front();
        checkOutput("done_missing", frame_count, de.fc);
      end
      prev_fc = frame_count;
    end
  end

  initial begin
    reset           = 1'b1;
    start_req       = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = '0;
    bus.pix_rd_addr = '0;
    bus.nn_done     = 1'b0;
    bus.nn_argmax   = '0;
    for (int i = 0; i < NUM_PIXELS; i++) model_known[i] = 1'b0;
    do_reset();

    $display("[TB] frame 1: ramp image");
    load_frame(1'b1, NUM_PIXELS);
`ifdef NN_AUTO_START_EN
    checkOutput("state_after_load", state, 3);
`else
    checkOutput("state_after_load", state, 2);
`endif
    read_pixel(5);
    read_pixel(783);
    read_pixel(0);
    repeat (3) read_pixel($urandom_range(0, NUM_PIXELS - 1));
`ifndef NN_AUTO_START_EN
    start_req = 1'b1;
    repeat (10) step();
    start_req = 1'b0;
    repeat (3) step();
    checkOutput("state_after_short_press", state, 2);
`endif
    launch();
    checkOutput("state_run", state, 3);
    checkOutput("result_valid_cleared", result_valid, 0);
    repeat ($urandom_range(1, 6)) step();
    finish_inference(4'd7, 1'b0, 8'h00);
    step();
    finish_inference(4'd9, 1'b0, 8'h00);
    repeat (2) step();
    checkOutput("done_outside_run_result", result, 7);
    checkOutput("done_outside_run_count", frame_count, 1);

    $display("[TB] frame 2: done with simultaneous byte");
    load_frame(1'b0, NUM_PIXELS);
    launch();
    finish_inference(4'd3, 1'b1, ~model_mem[0]);
    checkOutput("hist_two_frames", hist_flat, 32'h73);
    read_pixel(0);

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      load_frame(1'b0, NUM_PIXELS);
      if ($urandom_range(0, 1) == 1) applyStimulus(8'($urandom_range(0, 255)), 1'b0);
      launch();
      if ($urandom_range(0, 1) == 1) applyStimulus(8'($urandom_range(0, 255)), 1'b0);
      repeat ($urandom_range(0, 5)) step();
      finish_inference(4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      step();
      read_pixel(0);
      repeat (3) read_pixel($urandom_range(0, NUM_PIXELS - 1));
    end

    $display("[TB] reset mid-load");
    load_frame(1'b0, 300);
    do_reset();
    finish_inference(4'd5, 1'b0, 8'h00);
    repeat (3) step();
    checkOutput("post_reset_done_count", frame_count, 0);
    checkOutput("post_reset_done_state", state, 0);
    checkOutput("post_reset_done_result", result, 0);
    load_frame(1'b0, NUM_PIXELS);
    read_pixel(299);
    read_pixel(300);
    launch();
    finish_inference(4'($urandom_range(0, 15)), 1'b0, 8'h00);
    repeat (5) step();

    checkOutput("pending_reads", rd_q.size(), 0);
    checkOutput("pending_starts", start_q.size(), 0);
    checkOutput("pending_dones", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
